// File: rtl/emac_rx_nibble_reader_pkg.sv
// emac_rx_nibble_reader_pkg: shared state encodings, nibble constants and the queued beat record
package emac_rx_nibble_reader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LO, S_HI, S_DROP} state_e;
  localparam logic [3:0] NIB_PRE = 4'h5;
  localparam logic [3:0] NIB_SFD = 4'hD;
  localparam int ER_BIT = 5;
  localparam int DV_BIT = 4;
  typedef struct packed {
    logic       err;
    logic       last;
    logic [7:0] data;
  } beat_t;
endpackage

// File: rtl/emac_rx_byte_skid.sv
// emac_rx_byte_skid: 2-entry {err,last,data} queue; head is always entry 0
module emac_rx_byte_skid import emac_rx_nibble_reader_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop_ready,
  output beat_t      head,
  output logic       head_vld,
  output logic [1:0] q_occ
);
  beat_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] occ_q, occ_d, occ_pop;
  logic pop;
  always_comb begin
    pop = pop_ready && (occ_q != 2'd0);
    occ_pop = occ_q - {1'b0, pop};
    e0_d = pop ? e1_q : e0_q;
    e1_d = e1_q;
    if (push && occ_pop == 2'd0) e0_d = push_beat;
    if (push && occ_pop == 2'd1) e1_d = push_beat;
    occ_d = occ_pop + {1'b0, push};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q <= '0;
      e1_q <= '0;
      occ_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      occ_q <= occ_d;
    end
  end
  assign head = e0_q;
  assign head_vld = occ_q != 2'd0;
  assign q_occ = occ_q;
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && occ_pop == 2'd2))
    else $error("byte queue overflow");
endmodule

// File: rtl/emac_rx_nibble_reader.sv
// emac_rx_nibble_reader: strips preamble/SFD from MII FIFO entries and packs nibble pairs into a byte stream
module emac_rx_nibble_reader import emac_rx_nibble_reader_pkg::*; #(
  parameter int C_MAX_BYTES = 1518,
  parameter int C_CNT_WIDTH = 11
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Fifo_empty,
  output logic       Fifo_rd_en,
  input  logic       Fifo_rd_ack,
  input  logic [5:0] Fifo_dout,
  output logic [7:0] M_data,
  output logic       M_valid,
  input  logic       M_ready,
  output logic       M_last,
  output logic       M_err,
  output logic       Frame_drop
);
  state_e state_q, state_d;
  logic [3:0] lo_q, lo_d, n;
  logic [7:0] pend_q, pend_d;
  logic pend_vld_q, pend_vld_d, err_q, err_d, drop_q, drop_d, infl_q;
  logic push, do_flush, dv, er;
  logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0] q_occ;
  beat_t push_beat, head;
  assign dv = Fifo_dout[DV_BIT];
  assign er = Fifo_dout[ER_BIT];
  assign n = Fifo_dout[3:0];
  assign Fifo_rd_en = Rst_n && !Fifo_empty && (({1'b0, q_occ} + {2'b00, infl_q}) < 3'd2);
  always_comb begin
    state_d = state_q;
    lo_d = lo_q;
    pend_d = pend_q;
    pend_vld_d = pend_vld_q;
    err_d = err_q;
    cnt_d = cnt_q;
    drop_d = 1'b0;
    push = 1'b0;
    do_flush = 1'b0;
    push_beat = '{err: 1'b0, last: 1'b0, data: pend_q};
    if (Fifo_rd_ack) begin
      case (state_q)
        S_IDLE: if (dv) state_d = (n == NIB_PRE) ? S_PRE : (n == NIB_SFD) ? S_LO : S_DROP;
        S_PRE: begin
          state_d = !dv ? S_IDLE : (n == NIB_PRE) ? S_PRE : (n == NIB_SFD) ? S_LO : S_DROP;
          drop_d = !dv || (n != NIB_PRE && n != NIB_SFD);
        end
        S_LO: begin
          if (dv) begin
            lo_d = n;
            err_d = err_q | er;
            state_d = S_HI;
          end else do_flush = 1'b1;
        end
        S_HI: begin
          if (!dv) begin
            err_d = 1'b1;
            do_flush = 1'b1;
          end else if (cnt_q == C_CNT_WIDTH'(C_MAX_BYTES)) begin
            push = 1'b1;
            push_beat = '{err: 1'b1, last: 1'b1, data: pend_q};
            pend_vld_d = 1'b0;
            err_d = 1'b0;
            cnt_d = '0;
            state_d = S_DROP;
          end else begin
            push = pend_vld_q;
            pend_d = {n, lo_q};
            pend_vld_d = 1'b1;
            err_d = err_q | er;
            cnt_d = cnt_q + C_CNT_WIDTH'(1);
            state_d = S_LO;
          end
        end
        S_DROP: if (!dv) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    // Frame end: the held byte becomes last, or a byte-less frame is reported dropped
    if (do_flush) begin
      push = pend_vld_q;
      push_beat = '{err: err_d, last: 1'b1, data: pend_q};
      drop_d = !pend_vld_q;
      pend_vld_d = 1'b0;
      err_d = 1'b0;
      cnt_d = '0;
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      lo_q <= '0;
      pend_q <= '0;
      pend_vld_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      drop_q <= 1'b0;
      infl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      pend_q <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
      infl_q <= Fifo_rd_en;
    end
  end
  emac_rx_byte_skid u_skid (
    .clk(Clk),
    .rst_n(Rst_n),
    .push(push),
    .push_beat(push_beat),
    .pop_ready(M_ready),
    .head(head),
    .head_vld(M_valid),
    .q_occ(q_occ)
  );
  assign M_data = head.data;
  assign M_last = head.last;
  assign M_err = head.err;
  assign Frame_drop = drop_q;
  a_ack_after_pop: assert property (@(posedge Clk) disable iff (!Rst_n) Fifo_rd_ack |-> infl_q)
    else $error("Fifo_rd_ack without preceding Fifo_rd_en");
endmodule

// File: tb/tb_emac_rx_nibble_reader.sv
// tb_emac_rx_nibble_reader: table-driven frame vectors through a modelled MII FIFO, plus a mid-frame reset sequence
module tb_emac_rx_nibble_reader;
  localparam int MAXB = 64;
  logic Clk = 1'b0, Rst_n = 1'b0, Fifo_empty = 1'b1, Fifo_rd_ack = 1'b0, M_ready = 1'b1;
  logic [5:0] Fifo_dout = '0;
  logic Fifo_rd_en, M_valid, M_last, M_err, Frame_drop;
  logic [7:0] M_data;
  int errors = 0, checks = 0, drops = 0;
  bit toggle = 1'b0, stalled = 1'b0;
  logic [9:0] held;
  logic [5:0] fq[$];
  logic [9:0] got[$];
  typedef struct {
    string      name;
    int         nb;
    logic [7:0] start;
    logic [7:0] step;
    bit         pre;
    bit         sfd;
    bit         extra;
    int         er_idx;
    bit         tog;
    int         exp_beats;
    bit         exp_err;
    int         exp_drops;
  } vec_t;
  vec_t vecs[10];

  emac_rx_nibble_reader #(.C_MAX_BYTES(MAXB), .C_CNT_WIDTH(7)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Fifo_empty(Fifo_empty), .Fifo_rd_en(Fifo_rd_en),
    .Fifo_rd_ack(Fifo_rd_ack), .Fifo_dout(Fifo_dout), .M_data(M_data), .M_valid(M_valid),
    .M_ready(M_ready), .M_last(M_last), .M_err(M_err), .Frame_drop(Frame_drop)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: a pop seen before the edge returns its entry with ack in the next cycle
  initial begin
    bit take;
    forever begin
      @(negedge Clk);
      take = Fifo_rd_en;
      @(posedge Clk);
      #1;
      if (take && fq.size() > 0) begin
        Fifo_rd_ack = 1'b1;
        Fifo_dout = fq.pop_front();
      end else Fifo_rd_ack = 1'b0;
      Fifo_empty = fq.size() == 0;
    end
  end

  initial forever begin
    @(posedge Clk);
    #1 M_ready = toggle ? !M_ready : 1'b1;
  end

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (stalled) check("hold", int'({M_valid, M_err, M_last, M_data}), int'({1'b1, held}));
      stalled = M_valid && !M_ready;
      held = {M_err, M_last, M_data};
      if (M_valid && M_ready) got.push_back({M_err, M_last, M_data});
      if (Frame_drop) drops++;
    end else stalled = 1'b0;
  end

  task automatic push_frame(input vec_t v);
    logic [7:0] b;
    logic e;
    if (v.pre) repeat (15) fq.push_back({2'b01, 4'h5});
    if (v.sfd) fq.push_back({2'b01, 4'hD});
    for (int i = 0; i < v.nb; i++) begin
      b = v.start + 8'(i) * v.step;
      e = (i == v.er_idx);
      fq.push_back({e, 1'b1, b[3:0]});
      fq.push_back({e, 1'b1, b[7:4]});
    end
    if (v.extra) fq.push_back({2'b01, 4'h3});
    repeat (3) fq.push_back(6'h00);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (fq.size() > 0 && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 3000) check({name, " drain timeout"}, 1, 0);
    repeat (20) @(negedge Clk);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] exp_d;
    got.delete();
    drops = 0;
    toggle = v.tog;
    push_frame(v);
    wait_drain(v.name);
    toggle = 1'b0;
    check({v.name, " beats"}, got.size(), v.exp_beats);
    check({v.name, " drops"}, drops, v.exp_drops);
    for (int k = 0; k < got.size() && k < v.exp_beats; k++) begin
      exp_d = v.start + 8'(k) * v.step;
      check($sformatf("%s data[%0d]", v.name, k), int'(got[k][7:0]), int'(exp_d));
      check($sformatf("%s last[%0d]", v.name, k), int'(got[k][8]), int'(k == v.exp_beats - 1));
      check($sformatf("%s err[%0d]", v.name, k), int'(got[k][9]),
            int'(v.exp_err && k == v.exp_beats - 1));
    end
  endtask

  initial begin
    vec_t v;
    //         name        nb  start  step   pre   sfd   extra er  tog   beats err   drops
    vecs[0] = '{"good64",  64, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0, -1, 1'b0, 64, 1'b0, 0};
    vecs[1] = '{"toggle",  64, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0, -1, 1'b1, 64, 1'b0, 0};
    vecs[2] = '{"odd",      3, 8'h10, 8'h01, 1'b1, 1'b1, 1'b1, -1, 1'b0,  3, 1'b1, 0};
    vecs[3] = '{"rxer",    10, 8'h30, 8'h01, 1'b1, 1'b1, 1'b0,  1, 1'b0, 10, 1'b1, 0};
    vecs[4] = '{"trunc",   66, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0, -1, 1'b0, 64, 1'b1, 0};
    vecs[5] = '{"after",    4, 8'hA0, 8'h01, 1'b1, 1'b1, 1'b0, -1, 1'b0,  4, 1'b0, 0};
    vecs[6] = '{"preonly",  0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, -1, 1'b0,  0, 1'b0, 1};
    vecs[7] = '{"onebyte",  1, 8'hC3, 8'h00, 1'b1, 1'b1, 1'b0, -1, 1'b0,  1, 1'b0, 0};
    vecs[8] = '{"zerobyte", 0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, -1, 1'b0,  0, 1'b0, 1};
    vecs[9] = '{"junk",     1, 8'h21, 8'h00, 1'b0, 1'b0, 1'b0, -1, 1'b0,  0, 1'b0, 0};
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst M_valid", M_valid, 0);
    check("rst M_last", M_last, 0);
    check("rst M_err", M_err, 0);
    check("rst M_data", M_data, 0);
    check("rst Frame_drop", Frame_drop, 0);
    check("rst Fifo_rd_en", Fifo_rd_en, 0);
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    foreach (vecs[i]) run_vec(vecs[i]);
    // Reset in the middle of a frame: nothing from it may surface afterwards
    got.delete();
    v = '{"abort", 20, 8'h26, 8'h00, 1'b1, 1'b1, 1'b0, -1, 1'b0, 0, 1'b0, 0};
    push_frame(v);
    repeat (30) @(negedge Clk);
    @(posedge Clk);
    #1 Rst_n = 1'b0;
    @(negedge Clk);
    check("midrst M_valid", M_valid, 0);
    check("midrst M_last", M_last, 0);
    check("midrst M_err", M_err, 0);
    check("midrst M_data", M_data, 0);
    check("midrst Fifo_rd_en", Fifo_rd_en, 0);
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    got.delete();
    drops = 0;
    wait_drain("abort");
    check("abort leftover beats", got.size(), 0);
    check("abort leftover drops", drops, 0);
    v = '{"clean", 5, 8'hA1, 8'h11, 1'b1, 1'b1, 1'b0, -1, 1'b0, 5, 1'b0, 0};
    run_vec(v);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
